// File: rtl/t08_lcd_bus_responder.sv
// Display-side responder for the 8080-style parallel LCD bus.
// Decodes write strobes into a command byte plus packed parameter bytes, and
// answers read strobes by returning read_data one byte per strobe, MSB first.
module t08_lcd_bus_responder #(
  parameter int SYNC_STAGES     = 2,
  parameter int PARAM_BYTES_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csx,
  input  logic        dcx,
  input  logic        wrx,
  input  logic        rdx,
  input  logic [7:0]  bus_in,
  input  logic [31:0] read_data,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  output logic [7:0]  cmd_out,
  output logic        cmd_valid,
  output logic [31:0] param_out,
  output logic [2:0]  param_count,
  output logic        param_valid,
  output logic        txn_done,
  output logic        error
);

  localparam logic [2:0] PARAM_MAX = 3'(PARAM_BYTES_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD_WAIT = 2'd1,
    PARAM    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] csx_sync, dcx_sync, wrx_sync, rdx_sync;
  logic [7:0]             bus_sync [SYNC_STAGES];

  logic       csx_s, dcx_s, wrx_s, rdx_s;
  logic [7:0] bus_s;
  logic       csx_d, wrx_d, rdx_d;
  logic       conflict, blocked, gate;

  logic       ev_cs_fall, ev_cs_rise, ev_wr, ev_rd_fall, ev_rd_rise, ev_conflict;
  logic       dcx_q;
  logic [7:0] data_q;

  logic       do_cmd, do_param, do_err, do_done, do_close, do_rd_fall, do_rd_rise;

  logic       oe_q;
  logic [1:0] rd_index;
  logic       cmd_seen;

  assign csx_s = csx_sync[SYNC_STAGES-1];
  assign dcx_s = dcx_sync[SYNC_STAGES-1];
  assign wrx_s = wrx_sync[SYNC_STAGES-1];
  assign rdx_s = rdx_sync[SYNC_STAGES-1];
  assign bus_s = bus_sync[SYNC_STAGES-1];

  // Both strobes low at once is a protocol violation; edges stay frozen until both are high again.
  assign conflict = ~wrx_s & ~rdx_s;
  assign gate     = conflict | blocked;

  // The output enable is masked the moment csx is seen high, so it never overlaps a deselected bus.
  assign bus_oe = oe_q & ~csx_s;

  // Identical synchronizer chains keep data aligned with its strobes; strobes rest at their idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      csx_sync <= '1;
      wrx_sync <= '1;
      rdx_sync <= '1;
      dcx_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) bus_sync[i] <= '0;
    end else begin
      csx_sync    <= {csx_sync[SYNC_STAGES-2:0], csx};
      dcx_sync    <= {dcx_sync[SYNC_STAGES-2:0], dcx};
      wrx_sync    <= {wrx_sync[SYNC_STAGES-2:0], wrx};
      rdx_sync    <= {rdx_sync[SYNC_STAGES-2:0], rdx};
      bus_sync[0] <= bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) bus_sync[i] <= bus_sync[i-1];
    end
  end

  // Edge detection against one extra register, registered as single-cycle events with their byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      csx_d       <= 1'b1;
      wrx_d       <= 1'b1;
      rdx_d       <= 1'b1;
      blocked     <= 1'b0;
      ev_cs_fall  <= 1'b0;
      ev_cs_rise  <= 1'b0;
      ev_wr       <= 1'b0;
      ev_rd_fall  <= 1'b0;
      ev_rd_rise  <= 1'b0;
      ev_conflict <= 1'b0;
      dcx_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      csx_d       <= csx_s;
      wrx_d       <= wrx_s;
      rdx_d       <= rdx_s;
      if (conflict)
        blocked <= 1'b1;
      else if (wrx_s && rdx_s)
        blocked <= 1'b0;
      ev_cs_fall  <= csx_d & ~csx_s;
      ev_cs_rise  <= ~csx_d & csx_s;
      ev_wr       <= ~wrx_d & wrx_s & ~gate;
      ev_rd_fall  <= rdx_d & ~rdx_s & ~gate;
      ev_rd_rise  <= ~rdx_d & rdx_s & ~gate;
      ev_conflict <= conflict;
      dcx_q       <= dcx_s;
      data_q      <= bus_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and per-event action strobes; a csx rise overrides any coincident strobe.
  always_comb begin
    state_next = state;
    do_cmd     = 1'b0;
    do_param   = 1'b0;
    do_err     = 1'b0;
    do_done    = 1'b0;
    do_close   = 1'b0;
    do_rd_fall = 1'b0;
    do_rd_rise = 1'b0;
    case (state)
      IDLE: begin
        if (ev_cs_fall) state_next = CMD_WAIT;
      end
      CMD_WAIT, PARAM: begin
        if (ev_cs_rise) begin
          state_next = IDLE;
          do_close   = 1'b1;
          do_done    = cmd_seen;
        end else begin
          if (ev_conflict) do_err = 1'b1;
          if (ev_wr) begin
            if (!dcx_q) begin
              do_cmd     = 1'b1;
              state_next = PARAM;
            end else if (state == CMD_WAIT) begin
              do_err = 1'b1;
            end else if (param_count < PARAM_MAX) begin
              do_param = 1'b1;
            end else begin
              do_err = 1'b1;
            end
          end
          do_rd_fall = ev_rd_fall;
          do_rd_rise = ev_rd_rise;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath registers driven by the decoded actions.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_out     <= '0;
      oe_q        <= 1'b0;
      cmd_out     <= '0;
      cmd_valid   <= 1'b0;
      param_out   <= '0;
      param_count <= '0;
      param_valid <= 1'b0;
      txn_done    <= 1'b0;
      error       <= 1'b0;
      rd_index    <= '0;
      cmd_seen    <= 1'b0;
    end else begin
      cmd_valid   <= do_cmd;
      param_valid <= do_param;
      txn_done    <= do_done;
      if (do_err) error <= 1'b1;
      if (ev_conflict) oe_q <= 1'b0;
      if (do_rd_fall) begin
        oe_q <= 1'b1;
        case (rd_index)
          2'd0:    bus_out <= read_data[31:24];
          2'd1:    bus_out <= read_data[23:16];
          2'd2:    bus_out <= read_data[15:8];
          default: bus_out <= read_data[7:0];
        endcase
      end
      if (do_rd_rise) begin
        oe_q     <= 1'b0;
        rd_index <= rd_index + 2'd1;
      end
      if (do_cmd) begin
        cmd_out     <= data_q;
        param_out   <= '0;
        param_count <= '0;
        rd_index    <= '0;
        cmd_seen    <= 1'b1;
      end
      if (do_param) begin
        param_out   <= {param_out[23:0], data_q};
        param_count <= param_count + 3'd1;
      end
      if (do_close) begin
        oe_q     <= 1'b0;
        rd_index <= '0;
        cmd_seen <= 1'b0;
      end
    end
  end

endmodule
